// File: rtl/regfile_pkg.sv
// Shared sizing constants for the register file slice.
// The optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;
   localparam int ZERO_REG = 0;
endpackage

// File: rtl/regfile_if.sv
// Write/read bus of the register file; the master drives indices and write data.
interface regfile_if #(
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int ADDR_W = regfile_pkg::ADDR_W
);
   logic              ctrl_writeEnable;
   logic [ADDR_W-1:0] ctrl_writeReg;
   logic [DATA_W-1:0] data_writeReg;
   logic [ADDR_W-1:0] ctrl_readRegA;
   logic [ADDR_W-1:0] ctrl_readRegB;
   logic [DATA_W-1:0] data_readRegA;
   logic [DATA_W-1:0] data_readRegB;

   modport master (
      output ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readRegA, ctrl_readRegB,
      input  data_readRegA, data_readRegB
   );

   modport slave (
      input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readRegA, ctrl_readRegB,
      output data_readRegA, data_readRegB
   );
endinterface

// File: rtl/regfile_mux32.sv
// Combinational 32:1 word multiplexer used by each read port.
module mux32 #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic [DATA_W-1:0] din [1 << ADDR_W],
   input  logic [ADDR_W-1:0] sel,
   output logic [DATA_W-1:0] dout
);
   assign dout = din[sel];
endmodule

// File: rtl/regfile_reg32.sv
// One register-file entry: DATA_W flop with load enable and asynchronous clear.
module reg32 #(
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              en,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         q <= '0;
      else if (en)
         q <= d;
   end
endmodule

// File: rtl/regfile.sv
// 32-entry, two-read/one-write register file with hardwired-zero r0.
// Defining REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
module regfile #(
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int ADDR_W = regfile_pkg::ADDR_W
) (
   input  logic     clock,
   input  logic     reset,
   regfile_if.slave bus
);
   import regfile_pkg::*;

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:1] wr_en;
   logic [DATA_W-1:0]   mux_a;
   logic [DATA_W-1:0]   mux_b;

   assign regs[ZERO_REG] = '0;

   // Decoder output gated by the strobe, so an unknown index with the strobe low loads nothing.
   generate
      for (genvar gi = ZERO_REG + 1; gi < NUM_REGS; gi++) begin : g_reg
         assign wr_en[gi] = bus.ctrl_writeEnable && (bus.ctrl_writeReg == ADDR_W'(gi));

         reg32 #(.DATA_W(DATA_W)) u_reg (
            .clock (clock),
            .reset (reset),
            .en    (wr_en[gi]),
            .d     (bus.data_writeReg),
            .q     (regs[gi])
         );
      end
   endgenerate

   mux32 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux_a (
      .din  (regs),
      .sel  (bus.ctrl_readRegA),
      .dout (mux_a)
   );

   mux32 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux_b (
      .din  (regs),
      .sel  (bus.ctrl_readRegB),
      .dout (mux_b)
   );

`ifdef REGFILE_BYPASS_EN
   logic wr_live;
   logic fwd_a;
   logic fwd_b;

   // Forwarding is suppressed under reset so the ports still read zero.
   assign wr_live = !reset && bus.ctrl_writeEnable && (bus.ctrl_writeReg != ADDR_W'(ZERO_REG));
   assign fwd_a   = wr_live && (bus.ctrl_writeReg == bus.ctrl_readRegA);
   assign fwd_b   = wr_live && (bus.ctrl_writeReg == bus.ctrl_readRegB);

   assign bus.data_readRegA = fwd_a ? bus.data_writeReg : mux_a;
   assign bus.data_readRegB = fwd_b ? bus.data_writeReg : mux_b;
`else
   assign bus.data_readRegA = mux_a;
   assign bus.data_readRegB = mux_b;
`endif
endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: vector table, directed scenarios, random traffic vs. a reference array.
module tb_regfile;
   logic clock;
   logic reset;

   regfile_if #(.DATA_W(32), .ADDR_W(5)) rif ();

   regfile #(.DATA_W(32), .ADDR_W(5)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (rif)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   logic [31:0] mem [32];

   typedef struct {
      logic        we;
      logic [4:0]  wr;
      logic [31:0] wd;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, got, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                        input logic [4:0] ra, input logic [4:0] rb);
      rif.ctrl_writeEnable = we;
      rif.ctrl_writeReg    = wr;
      rif.data_writeReg    = wd;
      rif.ctrl_readRegA    = ra;
      rif.ctrl_readRegB    = rb;
   endtask

   // Reference: a write lands on the edge if strobed, non-zero index and reset low.
   task automatic tick();
      @(posedge clock);
      if (rif.ctrl_writeEnable && rif.ctrl_writeReg != 5'd0 && !reset)
         mem[rif.ctrl_writeReg] = rif.data_writeReg;
      if (reset)
         foreach (mem[i]) mem[i] = 32'h0;
      #1;
   endtask

   function automatic logic [31:0] expect_read(input logic [4:0] idx);
      if (reset || idx == 5'd0)
         return 32'h0;
`ifdef REGFILE_BYPASS_EN
      if (rif.ctrl_writeEnable && rif.ctrl_writeReg == idx)
         return rif.data_writeReg;
`endif
      return mem[idx];
   endfunction

   logic [31:0] old9;

   initial begin
      foreach (mem[i]) mem[i] = 32'h0;
      reset = 1'b1;
      drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

      // Scenario 1: write attempted while reset is held must be lost.
      drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
      #2;
      check("s1_reset_read_a", rif.data_readRegA, 32'h0);
      tick();
      check("s1_reset_edge_a", rif.data_readRegA, 32'h0);
      reset = 1'b0;
      drive(1'b0, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
      #1;
      check("s1_after_release", rif.data_readRegA, 32'h0);
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
         #1;
         check("reset_state_a", rif.data_readRegA, 32'h0);
      end
      drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
      tick();
      drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
      #1;
      check("s1_write_after_release", rif.data_readRegA, 32'hDEADBEEF);
      $display("txn s1: r5 write after reset release, A=%08h", rif.data_readRegA);

      // Vector table: reads are checked just before the edge that performs the write.
      vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd6,  5'd0,  32'h0,        32'h0};
      vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
      vecs[2] = '{1'b0, 5'd7,  32'h12345678, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
      vecs[3] = '{1'b1, 5'd31, 32'h80000001, 5'd7,  5'd0,  32'h0,        32'h0};
      vecs[4] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 32'h80000001, 32'h80000001};
      vecs[5] = '{1'b1, 5'd5,  32'h0000FFFF, 5'd31, 5'd0,  32'h80000001, 32'h0};
      vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'h0000FFFF, 32'h0};
      for (int v = 0; v < 7; v++) begin
         drive(vecs[v].we, vecs[v].wr, vecs[v].wd, vecs[v].ra, vecs[v].rb);
         #1;
         $display("txn vec%0d: we=%0b wr=%0d wd=%08h ra=%0d rb=%0d A=%08h B=%08h",
                  v, vecs[v].we, vecs[v].wr, vecs[v].wd, vecs[v].ra, vecs[v].rb,
                  rif.data_readRegA, rif.data_readRegB);
         check("vec_a", rif.data_readRegA, vecs[v].exp_a);
         check("vec_b", rif.data_readRegB, vecs[v].exp_b);
         tick();
      end

      // Scenario 2: writing r0 is ignored.
      drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
      tick();
      drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      #1;
      check("s2_r0_a", rif.data_readRegA, 32'h0);
      check("s2_r0_b", rif.data_readRegB, 32'h0);
      $display("txn s2: r0 write ignored, A=%08h B=%08h", rif.data_readRegA, rif.data_readRegB);

      // Scenario 3: distinct value per register, cross-read pairs.
      for (int i = 1; i < 32; i++) begin
         drive(1'b1, 5'(i), 32'h10000000 + 32'(i), 5'd0, 5'd0);
         tick();
      end
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
         #1;
         check("s3_pair_a", rif.data_readRegA, (i == 0) ? 32'h0 : 32'h10000000 + 32'(i));
         check("s3_pair_b", rif.data_readRegB, (i == 31) ? 32'h0 : 32'h10000000 + 32'(31 - i));
         $display("txn s3: A=r%0d %08h B=r%0d %08h", i, rif.data_readRegA, 31 - i, rif.data_readRegB);
      end

      // Scenario 4: strobe low for three edges leaves r7 alone.
      drive(1'b0, 5'd7, 32'h12345678, 5'd7, 5'd7);
      for (int k = 0; k < 3; k++) tick();
      check("s4_hold_r7", rif.data_readRegA, 32'h10000007);
      $display("txn s4: r7 after 3 disabled edges %08h", rif.data_readRegA);

      // Scenario 5: same-cycle write and read of r9.
      old9 = 32'h10000009;
      drive(1'b1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd9);
      #1;
`ifdef REGFILE_BYPASS_EN
      check("s5_same_cycle_a", rif.data_readRegA, 32'hCAFEF00D);
      check("s5_same_cycle_b", rif.data_readRegB, 32'hCAFEF00D);
`else
      check("s5_same_cycle_a", rif.data_readRegA, old9);
      check("s5_same_cycle_b", rif.data_readRegB, old9);
`endif
      tick();
      drive(1'b0, 5'd9, 32'h0, 5'd9, 5'd9);
      #1;
      check("s5_next_cycle", rif.data_readRegA, 32'hCAFEF00D);
      $display("txn s5: r9 next cycle %08h", rif.data_readRegA);

      // Scenario 6: mid-cycle reset pulse clears without a clock edge.
      drive(1'b1, 5'd3, 32'hAAAA5555, 5'd3, 5'd9);
      tick();
      drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd9);
      #1;
      check("s6_loaded", rif.data_readRegA, 32'hAAAA5555);
      reset = 1'b1;
      #1;
      check("s6_async_clear_a", rif.data_readRegA, 32'h0);
      check("s6_async_clear_b", rif.data_readRegB, 32'h0);
      reset = 1'b0;
      foreach (mem[i]) mem[i] = 32'h0;
      #1;
      check("s6_after_pulse", rif.data_readRegA, 32'h0);
      $display("txn s6: after reset pulse A=%08h B=%08h", rif.data_readRegA, rif.data_readRegB);

      // Random traffic against the reference array.
      for (int n = 0; n < 300; n++) begin
         drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         #1;
         check("rand_a", rif.data_readRegA, expect_read(rif.ctrl_readRegA));
         check("rand_b", rif.data_readRegB, expect_read(rif.ctrl_readRegB));
         $display("txn rand%0d: we=%0b wr=%0d wd=%08h ra=%0d A=%08h rb=%0d B=%08h",
                  n, rif.ctrl_writeEnable, rif.ctrl_writeReg, rif.data_writeReg,
                  rif.ctrl_readRegA, rif.data_readRegA, rif.ctrl_readRegB, rif.data_readRegB);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the register and data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, giving the register address width (2^ADDR_W = 32 registers).
REQ-003 The block SHALL have port clock  input  1  single clock; all register writes occur on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port ctrl_writeEnable  input  1  write strobe, sampled at rising clock.
REQ-006 The block SHALL have port ctrl_writeReg  input  ADDR_W  destination register index.
REQ-007 The block SHALL have port data_writeReg  input  DATA_W  write data.
REQ-008 The block SHALL have port ctrl_readRegA  input  ADDR_W  read port A index.
REQ-009 The block SHALL have port ctrl_readRegB  input  ADDR_W  read port B index.
REQ-010 The block SHALL have port data_readRegA  output  DATA_W  read port A data.
REQ-011 The block SHALL have port data_readRegB  output  DATA_W  read port B data.

Function
REQ-012 The block SHALL hold 32 registers r0..r31, each DATA_W bits.
REQ-013 When ctrl_writeEnable=1 at a rising clock edge and ctrl_writeReg!=0, data_writeReg SHALL be loaded into r[ctrl_writeReg]; all other registers SHALL hold.
REQ-014 r0 SHALL read as 0 at all times; writes to index 0 SHALL be ignored with no side effect.
REQ-015 Read ports SHALL be combinational: data_readRegA/B SHALL reflect r[ctrl_readRegA/B] within the same cycle, with zero clock latency.
REQ-016 A write SHALL be visible on the read ports from the cycle after the writing edge (one-cycle write-to-read latency, unless REQ-022 applies).
REQ-017 Ports A and B SHALL be independent; both addressing the same register SHALL return identical data.
REQ-018 Write data SHALL be stored unmodified at full DATA_W; no sign or zero extension SHALL be applied.
REQ-019 X/unknown inputs on ctrl_writeReg while ctrl_writeEnable=0 SHALL NOT alter any register.

Reset
REQ-020 Asserting reset SHALL immediately clear r0..r31 to 0, independent of clock; data_readRegA/B SHALL read 0 while reset is held.
REQ-021 Reset asserted coincident with a write edge SHALL win: the register SHALL be 0 after reset deasserts, and the first write SHALL take effect on the first rising edge with reset low.

Configuration
REQ-022 With REGFILE_BYPASS_EN defined, when ctrl_writeEnable=1, ctrl_writeReg!=0, and ctrl_writeReg equals a read index, that read port SHALL output data_writeReg in the same cycle (write-through forwarding); reset SHALL still force 0.
REQ-023 Without REGFILE_BYPASS_EN, no forwarding logic SHALL exist, and reads SHALL return the pre-edge value as in REQ-016.

Structure
REQ-024 DATA_W, ADDR_W, NUM_REGS=32, and the zero-register index SHALL be defined in the shared regfile_pkg header.
REQ-025 Each register SHALL be an instance of sub-module reg32 (DATA_W flop with enable and async active-high reset).
REQ-026 Each write enable SHALL be produced by a 5:32 decoder gated by ctrl_writeEnable.
REQ-027 Read selection SHALL use the existing 32:1 32-bit mux, one instance per port.

Verification
REQ-028 Scenario 1: reset=1, then write r5=0xDEADBEEF, release reset; read A=5 -> 0x00000000; then write r5=0xDEADBEEF with reset low; next cycle read A=5 -> 0xDEADBEEF.
REQ-029 Scenario 2: write r0=0xFFFFFFFF; read A=0 and B=0 -> 0x00000000 on both.
REQ-030 Scenario 3: write r1..r31 with value 0x1000_0000+i; read all pairs (A=i, B=31-i) -> each port returns its own index's value, with no aliasing.
REQ-031 Scenario 4: hold write r7=0x12345678 with ctrl_writeEnable=0 for 3 edges -> r7 unchanged.
REQ-032 Scenario 5: same cycle, write r9=0xCAFEF00D and read A=9 -> 0xCAFEF00D with REGFILE_BYPASS_EN defined, or the old r9 value without it; the following cycle returns 0xCAFEF00D in both builds.
REQ-033 Scenario 6: load r3=0xAAAA5555, then pulse reset mid-cycle between edges -> reads go to 0 before the next edge.
